coin_dispenser: RTL
===================

# coin_dispenser

Change-return engine paired with the vending FSM; it drives the same coin encoding that the FSM consumes. It accepts a change amount in coin units, then emits coins one per handshake, choosing greedily from two internally tracked stock counters. It ends every transaction with a one-cycle completion pulse that flags any shortfall. It sits between the vending controller's change request and the coin-return mechanism.

## Interface
Parameters:
- AMOUNT_W, 4, width of the requested change amount, in units (1 unit = small coin)
- STOCK_W, 6, width of each stock counter; counters saturate at 2^STOCK_W-1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; named `reset` as elsewhere in the codebase, but low = reset
- io_req_valid  in  1  change request valid
- io_req_ready  out  1  high only in IDLE
- io_req_amount  in  AMOUNT_W  change to return, in units
- io_coin_valid  out  1  coin presented
- io_coin_ready  in  1  mechanism accepts coin
- io_coin  out  1  coin kind, same encoding as the vending FSM input: 1 = small (1 unit), 0 = large (2 units)
- io_refill_valid  in  1  add stock; takes effect only in IDLE
- io_refill_small  in  STOCK_W  small coins to add
- io_refill_large  in  STOCK_W  large coins to add
- io_stock_small  out  STOCK_W  current small stock
- io_stock_large  out  STOCK_W  current large stock
- io_done  out  1  one-cycle pulse ending a transaction
- io_short  out  1  valid with io_done; 1 = remaining change was not paid
- io_short_amount  out  AMOUNT_W  unpaid units, valid with io_done

## Operation
- States: IDLE, EMIT, DONE.
- **IDLE**
  - io_req_ready=1.
  - On io_refill_valid, each stock becomes stock + refill, saturating at max.
  - On req handshake, remaining <= io_req_amount and the state goes to EMIT.
  - Simultaneous refill and request: both are taken. The refill is applied in the same edge, and coin selection uses the updated stock.
- **Coin selection** is combinational from the registered remaining and stocks:
  - Large if remaining>=2 and stock_large>0.
  - Otherwise small if remaining>=1 and stock_small>0.
  - Otherwise none.
- **EMIT**
  - io_coin_valid=1 iff a selection exists; io_coin = selection.
  - On coin handshake, remaining is decremented by the coin value and the matching stock by 1.
  - If no selection exists, the state goes to DONE with no coin presented.
- **DONE**
  - Lasts one cycle, then returns to IDLE.
  - Drives io_done=1, io_short=(remaining!=0), io_short_amount=remaining.
- io_refill_valid outside IDLE is ignored and lost; stock does not change.
- Greedy only, no backtracking. Example: amount 3 with stock_small=0, stock_large=5 pays one large coin and ends short by 1.

## Timing
- Reset (reset=0, asynchronous) drives:
  - State IDLE; remaining=0; both stocks=0.
  - io_req_ready=1, io_coin_valid=0, io_coin=1, io_done=0, io_short=0, io_short_amount=0.
- Request accepted at edge T puts the first coin on io_coin_valid in cycle T+1.
- Back-to-back coins: after a handshake at edge N, the next coin is valid in cycle N+1, so the sustained rate is one coin per cycle with io_coin_ready tied high.
- While io_coin_valid=1 and io_coin_ready=0:
  - io_coin is held stable.
  - Stocks and remaining do not change.
- After the last handshake, or on entering EMIT with nothing payable, the sequence is:
  - 1 cycle in EMIT with io_coin_valid=0;
  - DONE the following cycle;
  - io_req_ready=1 the cycle after DONE.
- Amount 0: EMIT(no coin) → DONE (short=0) → IDLE. io_done fires 2 cycles after acceptance.
- Reset asserted mid-transaction aborts immediately: no io_done, and stocks are cleared.

## Structure
- Shared package holds:
  - coin encoding constants COIN_SMALL=1'b1, COIN_LARGE=1'b0, shared with the vending FSM;
  - coin values (1, 2);
  - the state enum {IDLE, EMIT, DONE}.
- Sub-module coin_select: combinational greedy chooser. Inputs are remaining and the two stocks; outputs are valid and kind.
- Top holds the FSM, the remaining register and the saturating stock counters.

## Test plan
- Refill small=2, large=2, then request 5, coin_ready=1: coins 0,0,1 in cycles T+1..T+3; io_done with short=0; stocks end at small=1, large=0.
- Stock small=0, large=3, request 3: one coin 0, then io_done with short=1, short_amount=1.
- Request 4 with large=2 and coin_ready low for 3 cycles: io_coin stays 0 and valid the whole stall; exactly 2 coins are emitted.
- Refill and request in the same cycle (refill large=1, request 2, empty stock): one coin 0, short=0.
- Request 0: no coin_valid; io_done 2 cycles after acceptance with short=0. A refill driven during EMIT leaves stock unchanged.
- Assert reset during EMIT after the first coin: outputs return to their reset values asynchronously and stocks read 0; a new request is accepted after reset is released.

Source files
------------

// File: rtl/coin_dispenser_pkg.sv
// Shared definitions for the change-return engine and the vending FSM:
// coin encoding, coin values and the dispenser state enum.
package coin_dispenser_pkg;

  localparam logic COIN_SMALL = 1'b1;
  localparam logic COIN_LARGE = 1'b0;

  localparam int unsigned COIN_SMALL_VAL = 1;
  localparam int unsigned COIN_LARGE_VAL = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/coin_dispenser_coin_select.sv
// Combinational greedy coin chooser: prefers a large coin whenever it fits
// and is in stock, falls back to a small coin, otherwise reports no coin.
module coin_select
  import coin_dispenser_pkg::*;
#(
  parameter int AMOUNT_W = 4,
  parameter int STOCK_W  = 6
) (
  input  logic [AMOUNT_W-1:0] i_remaining,
  input  logic [STOCK_W-1:0]  i_stock_small,
  input  logic [STOCK_W-1:0]  i_stock_large,
  output logic                o_valid,
  output logic                o_kind
);

  logic w_large_ok;
  logic w_small_ok;

  assign w_large_ok = (i_remaining >= AMOUNT_W'(COIN_LARGE_VAL)) && (i_stock_large != '0);
  assign w_small_ok = (i_remaining >= AMOUNT_W'(COIN_SMALL_VAL)) && (i_stock_small != '0);

  always_comb begin
    o_valid = 1'b0;
    o_kind  = COIN_SMALL;
    if (w_large_ok) begin
      o_valid = 1'b1;
      o_kind  = COIN_LARGE;
    end else if (w_small_ok) begin
      o_valid = 1'b1;
      o_kind  = COIN_SMALL;
    end
  end

endmodule

// File: rtl/coin_dispenser.sv
// Change-return engine: accepts a change amount, pays it out one coin per
// handshake from two saturating stock counters, then pulses done/short.
module coin_dispenser
  import coin_dispenser_pkg::*;
#(
  parameter int AMOUNT_W = 4,
  parameter int STOCK_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [AMOUNT_W-1:0] io_req_amount,
  output logic                io_coin_valid,
  input  logic                io_coin_ready,
  output logic                io_coin,
  input  logic                io_refill_valid,
  input  logic [STOCK_W-1:0]  io_refill_small,
  input  logic [STOCK_W-1:0]  io_refill_large,
  output logic [STOCK_W-1:0]  io_stock_small,
  output logic [STOCK_W-1:0]  io_stock_large,
  output logic                io_done,
  output logic                io_short,
  output logic [AMOUNT_W-1:0] io_short_amount
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AMOUNT_W-1:0] r_remaining;
  logic [STOCK_W-1:0]  r_stock_small;
  logic [STOCK_W-1:0]  r_stock_large;

  logic                w_sel_valid;
  logic                w_sel_kind;
  logic                w_req_fire;
  logic                w_coin_fire;
  logic                w_refill_take;
  logic [AMOUNT_W-1:0] w_coin_val;

  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
  endfunction

  coin_select #(
    .AMOUNT_W (AMOUNT_W),
    .STOCK_W  (STOCK_W)
  ) u_coin_select (
    .i_remaining   (r_remaining),
    .i_stock_small (r_stock_small),
    .i_stock_large (r_stock_large),
    .o_valid       (w_sel_valid),
    .o_kind        (w_sel_kind)
  );

  assign w_req_fire    = (r_state == IDLE) && io_req_valid;
  assign w_refill_take = (r_state == IDLE) && io_refill_valid;
  assign w_coin_fire   = (r_state == EMIT) && w_sel_valid && io_coin_ready;
  assign w_coin_val    = (w_sel_kind == COIN_LARGE) ? AMOUNT_W'(COIN_LARGE_VAL)
                                                    : AMOUNT_W'(COIN_SMALL_VAL);

  always_comb begin
    w_state_nxt     = r_state;
    io_req_ready    = 1'b0;
    io_coin_valid   = 1'b0;
    io_coin         = COIN_SMALL;
    io_done         = 1'b0;
    io_short        = 1'b0;
    io_short_amount = '0;
    case (r_state)
      IDLE: begin
        io_req_ready = 1'b1;
        if (io_req_valid) w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_sel_valid) begin
          io_coin_valid = 1'b1;
          io_coin       = w_sel_kind;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        io_done         = 1'b1;
        io_short        = (r_remaining != '0);
        io_short_amount = r_remaining;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_stock_small <= '0;
      r_stock_large <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) r_remaining <= io_req_amount;
      // Refill lands on the acceptance edge so the first selection sees it.
      if (w_refill_take) begin
        r_stock_small <= sat_add(r_stock_small, io_refill_small);
        r_stock_large <= sat_add(r_stock_large, io_refill_large);
      end else if (w_coin_fire) begin
        r_remaining <= r_remaining - w_coin_val;
        if (w_sel_kind == COIN_LARGE) r_stock_large <= r_stock_large - 1'b1;
        else                          r_stock_small <= r_stock_small - 1'b1;
      end
    end
  end

  assign io_stock_small = r_stock_small;
  assign io_stock_large = r_stock_large;

endmodule
